// File: rtl/sprite_index_fetch_if.sv
// Sprite ROM bus: registered address out, palette index back one cycle later.
interface sprite_index_fetch_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0]        rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/sprite_index_fetch.sv
// Sprite pixel fetch: box hit, ROM address, aligned index, opaque count.
// Optional horizontal mirror enabled by macro SPRITE_FETCH_MIRROR_EN.
module sprite_index_fetch #(
  parameter int         SPR_W      = 64,
  parameter int         SPR_H      = 64,
  parameter int         ADDR_W     = 12,
  parameter logic [8:0] TRANSP_IDX = 9'd0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [9:0]  pos_x_in,
  input  logic [9:0]  pos_y_in,
  input  logic        flip_x_in,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_en,
  sprite_index_fetch_if.master rom,
  output logic [8:0]  index_out,
  output logic        hit_out,
  output logic        opaque_out,
  output logic        valid_out,
  output logic [12:0] opaque_count
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  typedef enum logic {
    WAIT_FRAME,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [9:0]        px_q, px_d;
  logic [9:0]        py_q, py_d;
  logic              flip_q, flip_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              s1_hit_q, s1_hit_d;
  logic              s1_pen_q, s1_pen_d;
  logic              s2_hit_q, s2_hit_d;
  logic              s2_pen_q, s2_pen_d;
  logic [8:0]        index_q, index_d;
  logic              hit_q, hit_d;
  logic              opaque_q, opaque_d;
  logic              valid_q, valid_d;
  logic [12:0]       cnt_q, cnt_d;
  logic [12:0]       count_q, count_d;

  logic              hit0;
  logic              in_x, in_y;
  logic [10:0]       dx, dy, px_e, py_e;
  logic [XW-1:0]     rx, rx_m;
  logic [YW-1:0]     ry;
  logic [ADDR_W-1:0] addr0;
  logic [12:0]       cnt_inc;

`ifndef SPRITE_FETCH_MIRROR_EN
  logic unused_flip;
  assign unused_flip = flip_q;
`endif

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    flip_d  = flip_q;
    if (frame_start) begin
      state_d = ACTIVE;
      px_d    = pos_x_in;
      py_d    = pos_y_in;
      flip_d  = flip_x_in;
    end

    // 11-bit compares so a box near the right edge never wraps
    dx   = {1'b0, DrawX};
    dy   = {1'b0, DrawY};
    px_e = {1'b0, px_q};
    py_e = {1'b0, py_q};
    in_x = (dx >= px_e) && (dx < px_e + 11'(SPR_W));
    in_y = (dy >= py_e) && (dy < py_e + 11'(SPR_H));
    hit0 = pix_en && (state_q == ACTIVE) && in_x && in_y;

    rx = XW'(DrawX - px_q);
    ry = YW'(DrawY - py_q);
`ifdef SPRITE_FETCH_MIRROR_EN
    rx_m = flip_q ? (XW'(SPR_W - 1) - rx) : rx;
`else
    rx_m = rx;
`endif
    addr0 = (ADDR_W'(ry) << XW) | ADDR_W'(rx_m);

    rom_addr_d = hit0 ? addr0 : rom_addr_q;
    s1_hit_d   = hit0;
    s1_pen_d   = pix_en;
    s2_hit_d   = s1_hit_q;
    s2_pen_d   = s1_pen_q;

    index_d  = s2_hit_q ? rom.rom_data : TRANSP_IDX;
    hit_d    = s2_hit_q;
    opaque_d = s2_hit_q && (rom.rom_data != TRANSP_IDX);
    valid_d  = s2_pen_q;

    cnt_inc = cnt_q;
    if (opaque_q && (cnt_q != 13'h1FFF))
      cnt_inc = cnt_q + 13'd1;
    cnt_d   = cnt_inc;
    count_d = count_q;
    if (frame_start) begin
      count_d = cnt_inc;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= WAIT_FRAME;
      px_q       <= '0;
      py_q       <= '0;
      flip_q     <= 1'b0;
      rom_addr_q <= '0;
      s1_hit_q   <= 1'b0;
      s1_pen_q   <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_pen_q   <= 1'b0;
      index_q    <= '0;
      hit_q      <= 1'b0;
      opaque_q   <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      flip_q     <= flip_d;
      rom_addr_q <= rom_addr_d;
      s1_hit_q   <= s1_hit_d;
      s1_pen_q   <= s1_pen_d;
      s2_hit_q   <= s2_hit_d;
      s2_pen_q   <= s2_pen_d;
      index_q    <= index_d;
      hit_q      <= hit_d;
      opaque_q   <= opaque_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign index_out    = index_q;
  assign hit_out      = hit_q;
  assign opaque_out   = opaque_q;
  assign valid_out    = valid_q;
  assign opaque_count = count_q;

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Directed bench for sprite_index_fetch with a synchronous ROM model.
module tb_sprite_index_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  pos_x_in = '0;
  logic [9:0]  pos_y_in = '0;
  logic        flip_x_in = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        pix_en = 1'b0;
  logic [8:0]  index_out;
  logic        hit_out;
  logic        opaque_out;
  logic        valid_out;
  logic [12:0] opaque_count;

  int rom_mode = 0;
  int n_pass = 0;
  int n_tot = 0;

  sprite_index_fetch_if #(.ADDR_W(12)) rif ();

  sprite_index_fetch #(
    .SPR_W(64), .SPR_H(64), .ADDR_W(12), .TRANSP_IDX(9'd0)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_start(frame_start),
    .pos_x_in(pos_x_in),
    .pos_y_in(pos_y_in),
    .flip_x_in(flip_x_in),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .pix_en(pix_en),
    .rom(rif),
    .index_out(index_out),
    .hit_out(hit_out),
    .opaque_out(opaque_out),
    .valid_out(valid_out),
    .opaque_count(opaque_count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [8:0] rom_fn(input int m, input logic [11:0] a);
    case (m)
      0:       return a[8:0] + 9'd3;
      1:       return 9'd5;
      default: return (a < 12'd1000) ? 9'd0 : 9'd7;
    endcase
  endfunction

  always @(posedge Clk) rif.rom_data <= rom_fn(rom_mode, rif.rom_addr);

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame(input int x, input int y, input logic f);
    pos_x_in = 10'(x);
    pos_y_in = 10'(y);
    flip_x_in = f;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_px(input int x, input int y,
                         output logic [11:0] a, output logic h1,
                         output logic h2, output logic [8:0] idx,
                         output logic op, output logic vo);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pix_en = 1'b1;
    step();
    a = rif.rom_addr;
    pix_en = 1'b0;
    step();
    h1 = hit_out;
    step();
    h2 = hit_out;
    idx = index_out;
    op = opaque_out;
    vo = valid_out;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    pix_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      DrawX = 10'(i * 7);
      DrawY = 10'(i);
      step();
    end
    n_tot++;
    if ({rif.rom_addr, index_out, hit_out, opaque_out, valid_out,
         opaque_count} !== '0)
      $display("FAIL reset_outputs: addr=%0d idx=%0d hit=%b op=%b v=%b cnt=%0d, need all 0",
               rif.rom_addr, index_out, hit_out, opaque_out, valid_out,
               opaque_count);
    else n_pass++;
    Reset_n = 1'b1;
    DrawX = 10'd5;
    DrawY = 10'd5;
    for (int i = 0; i < 4; i++) step();
    n_tot++;
    if (hit_out !== 1'b0 || valid_out !== 1'b1)
      $display("FAIL wait_frame_hit: hit=%b valid=%b, need hit=0 valid=1",
               hit_out, valid_out);
    else n_pass++;
    n_tot++;
    if (rif.rom_addr !== 12'd0)
      $display("FAIL wait_frame_addr: addr=%0d, need 0", rif.rom_addr);
    else n_pass++;
    idle(3);
  endtask

  task automatic test_basic();
    logic [11:0] a;
    logic h1, h2, op, vo;
    logic [8:0] idx;
    rom_mode = 0;
    frame(100, 50, 1'b0);
    n_tot++;
    if (opaque_count !== 13'd0)
      $display("FAIL first_publish: count=%0d, need 0", opaque_count);
    else n_pass++;
    send_px(100, 50, a, h1, h2, idx, op, vo);
    n_tot++;
    if (a !== 12'd0 || h1 !== 1'b0 || h2 !== 1'b1 || idx !== 9'd3 ||
        op !== 1'b1 || vo !== 1'b1)
      $display("FAIL origin_px: addr=%0d h1=%b h2=%b idx=%0d op=%b v=%b, need 0 0 1 3 1 1",
               a, h1, h2, idx, op, vo);
    else n_pass++;
    send_px(163, 50, a, h1, h2, idx, op, vo);
    n_tot++;
    if (a !== 12'd63 || h2 !== 1'b1 || idx !== 9'd66)
      $display("FAIL right_edge: addr=%0d hit=%b idx=%0d, need 63 1 66",
               a, h2, idx);
    else n_pass++;
    send_px(164, 50, a, h1, h2, idx, op, vo);
    n_tot++;
    if (a !== 12'd63 || h2 !== 1'b0 || idx !== 9'd0 || op !== 1'b0 ||
        vo !== 1'b1)
      $display("FAIL past_right: addr=%0d hit=%b idx=%0d op=%b v=%b, need 63 0 0 0 1",
               a, h2, idx, op, vo);
    else n_pass++;
    send_px(100, 113, a, h1, h2, idx, op, vo);
    n_tot++;
    if (a !== 12'd4032 || h2 !== 1'b1 || idx !== 9'd451)
      $display("FAIL bottom_row: addr=%0d hit=%b idx=%0d, need 4032 1 451",
               a, h2, idx);
    else n_pass++;
    send_px(100, 114, a, h1, h2, idx, op, vo);
    n_tot++;
    if (h2 !== 1'b0)
      $display("FAIL below_box: hit=%b, need 0", h2);
    else n_pass++;
    send_px(99, 50, a, h1, h2, idx, op, vo);
    n_tot++;
    if (h2 !== 1'b0)
      $display("FAIL left_of_box: hit=%b, need 0", h2);
    else n_pass++;
    send_px(161, 57, a, h1, h2, idx, op, vo);
    n_tot++;
    if (a !== 12'd509 || h2 !== 1'b1 || idx !== 9'd0 || op !== 1'b0)
      $display("FAIL transparent_px: addr=%0d hit=%b idx=%0d op=%b, need 509 1 0 0",
               a, h2, idx, op);
    else n_pass++;
  endtask

  task automatic test_clip();
    int hits = 0;
    int low_hits = 0;
    int bad = 0;
    rom_mode = 1;
    frame(620, 0, 1'b0);
    DrawY = 10'd0;
    for (int x = 0; x < 642; x++) begin
      pix_en = (x < 640);
      DrawX = 10'(x < 640 ? x : 0);
      step();
      if (x >= 2) begin
        if (hit_out === 1'b1) begin
          hits++;
          if (x - 2 < 44) low_hits++;
          if (x - 2 < 620 || index_out !== 9'd5) bad++;
        end
      end
    end
    n_tot++;
    if (hits != 20)
      $display("FAIL clip_hits: got %0d, need 20", hits);
    else n_pass++;
    n_tot++;
    if (low_hits != 0)
      $display("FAIL clip_wrap: got %0d, need 0", low_hits);
    else n_pass++;
    n_tot++;
    if (bad != 0)
      $display("FAIL clip_place: %0d bad hits, need 0", bad);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_shadow();
    logic [11:0] a;
    logic h1, h2, op, vo;
    logic [8:0] idx;
    rom_mode = 0;
    frame(100, 50, 1'b0);
    pos_x_in = 10'd300;
    send_px(300, 50, a, h1, h2, idx, op, vo);
    n_tot++;
    if (h2 !== 1'b0)
      $display("FAIL shadow_new_ignored: hit=%b, need 0", h2);
    else n_pass++;
    send_px(101, 50, a, h1, h2, idx, op, vo);
    n_tot++;
    if (a !== 12'd1 || h2 !== 1'b1)
      $display("FAIL shadow_old_kept: addr=%0d hit=%b, need 1 1", a, h2);
    else n_pass++;
    DrawX = 10'd102;
    DrawY = 10'd50;
    pix_en = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_en = 1'b0;
    n_tot++;
    if (rif.rom_addr !== 12'd2)
      $display("FAIL inflight_addr: addr=%0d, need 2", rif.rom_addr);
    else n_pass++;
    step();
    step();
    n_tot++;
    if (hit_out !== 1'b1 || index_out !== 9'd5)
      $display("FAIL inflight_out: hit=%b idx=%0d, need 1 5",
               hit_out, index_out);
    else n_pass++;
    send_px(305, 51, a, h1, h2, idx, op, vo);
    n_tot++;
    if (a !== 12'd69 || h2 !== 1'b1 || idx !== 9'd72)
      $display("FAIL shadow_new_used: addr=%0d hit=%b idx=%0d, need 69 1 72",
               a, h2, idx);
    else n_pass++;
    send_px(100, 50, a, h1, h2, idx, op, vo);
    n_tot++;
    if (h2 !== 1'b0)
      $display("FAIL shadow_old_gone: hit=%b, need 0", h2);
    else n_pass++;
  endtask

  task automatic test_count();
    rom_mode = 2;
    frame(100, 50, 1'b0);
    for (int y = 50; y < 114; y++) begin
      for (int x = 100; x < 164; x++) begin
        DrawX = 10'(x);
        DrawY = 10'(y);
        pix_en = 1'b1;
        step();
      end
    end
    idle(3);
    frame(100, 50, 1'b0);
    n_tot++;
    if (opaque_count !== 13'd3096)
      $display("FAIL opaque_count: got %0d, need 3096", opaque_count);
    else n_pass++;
    idle(2);
    frame(100, 50, 1'b0);
    n_tot++;
    if (opaque_count !== 13'd0)
      $display("FAIL count_restart: got %0d, need 0", opaque_count);
    else n_pass++;
  endtask

  task automatic test_mirror();
    logic [11:0] a;
    logic h1, h2, op, vo;
    logic [8:0] idx;
    logic [11:0] exp_a;
`ifdef SPRITE_FETCH_MIRROR_EN
    exp_a = 12'd63;
`else
    exp_a = 12'd0;
`endif
    rom_mode = 0;
    frame(100, 50, 1'b1);
    send_px(100, 50, a, h1, h2, idx, op, vo);
    n_tot++;
    if (a !== exp_a || h2 !== 1'b1 || idx !== exp_a[8:0] + 9'd3)
      $display("FAIL mirror_addr: addr=%0d hit=%b idx=%0d, need %0d 1 %0d",
               a, h2, idx, exp_a, exp_a + 12'd3);
    else n_pass++;
    frame(100, 50, 1'b0);
  endtask

  task automatic test_midreset();
    frame(100, 50, 1'b0);
    DrawX = 10'd100;
    DrawY = 10'd50;
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
    n_tot++;
    if (hit_out !== 1'b0 || valid_out !== 1'b0 || rif.rom_addr !== 12'd0)
      $display("FAIL midreset_flush: hit=%b valid=%b addr=%0d, need 0 0 0",
               hit_out, valid_out, rif.rom_addr);
    else n_pass++;
    DrawX = 10'd3;
    DrawY = 10'd3;
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    step();
    step();
    n_tot++;
    if (hit_out !== 1'b0 || valid_out !== 1'b1)
      $display("FAIL midreset_wait: hit=%b valid=%b, need 0 1",
               hit_out, valid_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_shadow();
    test_count();
    test_mirror();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sprite_index_fetch.md
Name: sprite_index_fetch

Overview:
- Pipelined sprite pixel fetch stage that sits directly upstream of the 9-bit-index palette lookup.
- Takes the VGA scan position and the sprite origin, and drives the address of a synchronous sprite ROM holding 9-bit palette indices.
- Outputs an aligned palette index plus hit/opaque flags, which the palette and colour mapper consume.
- Also counts the opaque sprite pixels drawn in each frame, for collision logic.

Parameters:
- SPR_W, 64, sprite width in pixels (power of two).
- SPR_H, 64, sprite height in pixels.
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H.
- TRANSP_IDX, 0, palette index treated as transparent.

Ports:
- Clk  in  1  system/pixel clock.
- Reset_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at vsync start.
- pos_x_in  in  10  sprite origin X; sampled only on frame_start.
- pos_y_in  in  10  sprite origin Y; sampled only on frame_start.
- flip_x_in  in  1  horizontal mirror request; sampled on frame_start.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- pix_en  in  1  high during the active display region.
- rom_addr  out  ADDR_W  registered sprite ROM address.
- rom_data  in  9  ROM output, valid one cycle after rom_addr.
- index_out  out  9  palette index aligned with hit_out.
- hit_out  out  1  pixel lies inside the sprite box.
- opaque_out  out  1  hit_out and index_out != TRANSP_IDX.
- valid_out  out  1  pix_en delayed by 2 cycles.
- opaque_count  out  13  opaque pixels counted in the previous frame.

Behaviour:
- Reset, sampled on the Clk edge while Reset_n=0, sets:
  - rom_addr=0, index_out=0, hit_out=0, opaque_out=0, valid_out=0, opaque_count=0;
  - shadow position = 0, shadow flip = 0;
  - state = WAIT_FRAME;
  - all pipeline valid/hit bits cleared.
- Reset asserted mid-frame discards all in-flight pixels.
- State machine:
  - WAIT_FRAME -> ACTIVE on frame_start.
  - ACTIVE -> ACTIVE on every subsequent frame_start. There is no path back except reset.
  - In WAIT_FRAME, hit_out/opaque_out are forced 0, while valid_out still tracks pix_en.
- Shadow registers:
  - pos_x, pos_y and flip are latched only on the frame_start cycle, so mid-frame changes cannot tear the image.
- Stage 0, on the edge that samples DrawX/DrawY:
  - hit0 = pix_en & ACTIVE & (DrawX >= px) & (DrawX < px+SPR_W) & (DrawY >= py) & (DrawY < py+SPR_H).
  - The compares use 11-bit zero-extended sums, so a sprite at px=620 clips at 639 without wrap.
  - rx = DrawX-px and ry = DrawY-py, truncated to log2 widths.
  - rom_addr <= ry*SPR_W + rx when hit0; otherwise rom_addr holds its previous value.
- Stage 1: rom_data is presented by the ROM. hit1 and pix_en are delayed by one register.
- Stage 2:
  - index_out <= hit1 ? rom_data : TRANSP_IDX.
  - hit_out <= hit1.
  - opaque_out <= hit1 & (rom_data != TRANSP_IDX).
  - valid_out <= pix_en delayed.
- Latency: exactly 2 Clk cycles from the DrawX/DrawY sample to index_out/hit_out. The pipeline is fixed with no stalls and accepts one pixel per cycle.
- Opaque counter:
  - An internal 13-bit counter increments on each cycle with opaque_out=1 (the registered value), saturating at 8191.
  - On frame_start: opaque_count <= counter (including an increment in that same cycle), then the counter clears to 0.
  - The first frame_start after reset publishes 0.
- Simultaneous events: frame_start with in-flight pixels. Those pixels complete using the old pipeline contents; only new samples use the new shadow position.

Optional Feature:
- Macro SPRITE_FETCH_MIRROR_EN.
- Defined: when the latched flip=1, rx is replaced by SPR_W-1-rx before address formation. Latency and all else are unchanged.
- Undefined: the flip_x_in port still exists but is ignored; no mirror logic is synthesised.

Test Plan:
- Reset with Reset_n=0 for 3 cycles, with DrawX/DrawY sweeping -> all outputs 0, and hit_out stays 0 until the first frame_start.
- frame_start with pos=(100,50); DrawX=100, DrawY=50, pix_en=1 -> rom_addr=0 the next cycle; index_out=rom_data and hit_out=1 exactly 2 cycles after the sample. DrawX=163 gives rom_addr=63; DrawX=164 gives hit_out=0 and index_out=TRANSP_IDX.
- pos=(620,0) and a ROM returning 5 everywhere; scan row 0 -> hit_out high for DrawX 620..639 only, with no wrap hit at DrawX 0..43.
- Change pos_x_in mid-frame from 100 to 300 -> addressing stays at 100 until the next frame_start, then uses 300.
- Full 64x64 sprite, ROM returning 0 for 1000 addresses and 7 otherwise -> opaque_count=3096 after the next frame_start, and the counter restarts at 0.
- With SPRITE_FETCH_MIRROR_EN and flip_x_in=1 latched; DrawX=px, DrawY=py -> rom_addr=63. With the macro off -> rom_addr=0.
